// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-clk valid/frame_err strobes.
// Define UART_RX_PARITY_EN for an 8E1 frame with an extra parity bit and a parity_err strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       rx,
  output logic [7:0] d_in,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state_reg, state_next;
  logic             rx_meta_reg, rx_s_reg;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shreg_reg, shreg_next;
  logic [7:0]       d_in_reg, d_in_next;
  logic             valid_reg, valid_next;
  logic             frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic             parity_bit_reg, parity_bit_next;
  logic             parity_err_reg, parity_err_next;
`endif

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shreg_reg      <= '0;
      d_in_reg       <= '0;
      valid_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shreg_reg      <= shreg_next;
      d_in_reg       <= d_in_next;
      valid_reg      <= valid_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
    bit_idx_next    = bit_idx_reg;
    shreg_next      = shreg_reg;
    d_in_next       = d_in_reg;
    valid_next      = 1'b0;
    frame_err_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
    parity_err_next = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        bit_cnt_next = '0;
        if (!rx_s_reg) state_next = START;
      end
      START: begin
        // Re-check the line half a bit in; anything shorter is a glitch.
        if (bit_cnt_reg == HALF_LAST) begin
          bit_cnt_next = '0;
          if (!rx_s_reg) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_cnt_reg == BIT_LAST) begin
          shreg_next[bit_idx_reg] = rx_s_reg;
          bit_idx_next            = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_cnt_reg == BIT_LAST) begin
          parity_bit_next = rx_s_reg;
          state_next      = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_cnt_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
          parity_err_next = (^shreg_reg) ^ parity_bit_reg;
`endif
          if (rx_s_reg) begin
            d_in_next  = shreg_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait out a held-low line so it is not re-read as a stream of start bits.
        bit_cnt_next = '0;
        if (rx_s_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign d_in      = d_in_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule
